// File: rtl/bit_serializer_pkg.sv
// Shared types and helpers for the parallel-to-serial feeder in front of the
// 1011 sequence detector.
package ser_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_t;

   function automatic int unsigned cnt_w(input int unsigned width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serializer_if.sv
// Word-in / bit-out handshake bundle for bit_serializer; master is the word
// producer side, slave is the serializer itself.
interface bit_serializer_if #(
   parameter int unsigned WIDTH = 8
);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             sout;
   logic             sout_valid;
   logic             busy;

   modport master (
      output din,
      output din_valid,
      input  din_ready,
      input  sout,
      input  sout_valid,
      input  busy
   );

   modport slave (
      input  din,
      input  din_valid,
      output din_ready,
      output sout,
      output sout_valid,
      output busy
   );

endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: accepts WIDTH-bit words on a valid/ready handshake
// and streams them out one bit per clock with no gap between back-to-back words.
module bit_serializer
   import ser_pkg::*;
#(
   parameter int unsigned WIDTH     = 8,
   parameter bit          MSB_FIRST = 1'b1,
   parameter logic        IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   bit_serializer_if.slave  bus
);

   localparam int unsigned     CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   ser_state_t        state_q, state_d;
   logic [WIDTH-1:0]  shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q,   cnt_d;
   logic              sout_q,  sout_d;
   logic              sout_valid_q, sout_valid_d;

   logic              last_bit;
   logic              ready;
   logic              xfer;

   assign last_bit = (cnt_q == LAST);
   assign ready    = rst && ((state_q == IDLE) || ((state_q == SHIFT) && last_bit));
   assign xfer     = bus.din_valid && ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         shreg_q      <= '0;
         cnt_q        <= '0;
         sout_q       <= IDLE_BIT;
         sout_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         sout_q       <= sout_d;
         sout_valid_q <= sout_valid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (xfer) begin
         state_d = SHIFT;
      end else if ((state_q == SHIFT) && last_bit) begin
         state_d = IDLE;
      end
   end

   // The register rotates rather than zero-fills so every bit stays live; only
   // the bit next to the output end is ever observed, so the wire is identical.
   always_comb begin
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      sout_d       = sout_q;
      sout_valid_d = sout_valid_q;
      if (xfer) begin
         shreg_d      = bus.din;
         cnt_d        = '0;
         sout_d       = MSB_FIRST ? bus.din[WIDTH-1] : bus.din[0];
         sout_valid_d = 1'b1;
      end else if ((state_q == SHIFT) && !last_bit) begin
         cnt_d = cnt_q + CW'(1);
         if (MSB_FIRST) begin
            shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
            sout_d  = shreg_q[WIDTH-2];
         end else begin
            shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
            sout_d  = shreg_q[1];
         end
      end else if (state_q == SHIFT) begin
         sout_d       = IDLE_BIT;
         sout_valid_d = 1'b0;
      end
   end

   assign bus.din_ready  = ready;
   assign bus.sout       = sout_q;
   assign bus.sout_valid = sout_valid_q;
   assign bus.busy       = sout_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: an MSB-first/idle-0 and an LSB-first/idle-1 copy
// driven in lockstep and compared against a queue-of-bits reference model.
module tb_bit_serializer;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   bit_serializer_if #(.WIDTH(8)) bm ();
   bit_serializer_if #(.WIDTH(8)) bl ();

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk (clk),
      .rst (rst),
      .bus (bm.slave)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut_l (
      .clk (clk),
      .rst (rst),
      .bus (bl.slave)
   );

   int unsigned vectors    = 0;
   int unsigned miscompares = 0;

   // Reference model: bits still owed to the wire, plus the bit currently shown.
   bit          mv;
   bit          mb_m, mb_l;
   bit          rem_m[$];
   bit          rem_l[$];
   logic [15:0] seen_m, seen_l;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit exp_ready();
      return rst && (!mv || rem_m.size() == 0);
   endfunction

   task automatic model_reset();
      mv   = 1'b0;
      mb_m = 1'b0;
      mb_l = 1'b1;
      rem_m.delete();
      rem_l.delete();
   endtask

   task automatic model_edge(input logic [7:0] d, input logic v);
      if (!rst) begin
         model_reset();
      end else if (v && exp_ready()) begin
         rem_m.delete();
         rem_l.delete();
         for (int i = 7; i >= 0; i--) rem_m.push_back(d[i]);
         for (int i = 0; i < 8; i++)  rem_l.push_back(d[i]);
         mb_m = rem_m.pop_front();
         mb_l = rem_l.pop_front();
         mv   = 1'b1;
      end else if (mv && rem_m.size() > 0) begin
         mb_m = rem_m.pop_front();
         mb_l = rem_l.pop_front();
      end else begin
         mv   = 1'b0;
         mb_m = 1'b0;
         mb_l = 1'b1;
      end
   endtask

   task automatic check_out();
      chk("sout_m",       16'(bm.sout),       16'(mb_m));
      chk("sout_valid_m", 16'(bm.sout_valid), 16'(mv));
      chk("busy_m",       16'(bm.busy),       16'(mv));
      chk("sout_l",       16'(bl.sout),       16'(mb_l));
      chk("sout_valid_l", 16'(bl.sout_valid), 16'(mv));
      chk("busy_l",       16'(bl.busy),       16'(mv));
   endtask

   task automatic step(input logic [7:0] d, input logic v);
      bm.din = d;  bm.din_valid = v;
      bl.din = d;  bl.din_valid = v;
      #1;
      chk("din_ready_m", 16'(bm.din_ready), 16'(exp_ready()));
      chk("din_ready_l", 16'(bl.din_ready), 16'(exp_ready()));
      @(posedge clk);
      model_edge(d, v);
      #1;
      check_out();
      seen_m = {seen_m[14:0], bm.sout};
      seen_l = {seen_l[14:0], bl.sout};
   endtask

   initial begin
      rst = 1'b1;
      bm.din = '0;  bm.din_valid = 1'b0;
      bl.din = '0;  bl.din_valid = 1'b0;
      seen_m = '0;  seen_l = '0;
      model_reset();

      #2 rst = 1'b0;
      #1;
      check_out();
      chk("ready_in_reset", 16'(bm.din_ready), 16'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      // Single word
      step(8'hB0, 1'b1);
      repeat (7) step(8'h00, 1'b0);
      chk("single_bits_m", 16'(seen_m[7:0]), 16'h00B0);
      step(8'h00, 1'b0);

      // Back-to-back with garbage on din while not ready
      step(8'hB5, 1'b1);
      repeat (7) step(8'($urandom), 1'b1);
      step(8'h6D, 1'b1);
      repeat (7) step(8'($urandom), 1'b0);
      chk("b2b_bits_m", seen_m, 16'hB56D);
      step(8'h00, 1'b0);

      // LSB-first word
      step(8'h0D, 1'b1);
      repeat (7) step(8'($urandom), 1'b1);
      chk("lsb_bits_l", 16'(seen_l[7:0]), 16'h00B0);
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);

      // Two-cycle idle gap
      step(8'hB0, 1'b1);
      repeat (9) step(8'h00, 1'b0);
      step(8'h0B, 1'b1);
      repeat (7) step(8'h00, 1'b0);
      step(8'h00, 1'b0);

      // Reset mid-word
      step(8'hFF, 1'b1);
      step(8'h00, 1'b0);
      step(8'h00, 1'b0);
      #2 rst = 1'b0;
      #1;
      model_reset();
      check_out();
      chk("ready_async_rst", 16'(bl.din_ready), 16'd0);
      step(8'h0F, 1'b1);
      #2 rst = 1'b1;
      step(8'h0F, 1'b1);
      repeat (7) step(8'h00, 1'b0);
      chk("post_rst_bits_m", 16'(seen_m[7:0]), 16'h000F);
      chk("post_rst_bits_l", 16'(seen_l[7:0]), 16'h00F0);
      step(8'h00, 1'b0);

      // Random traffic
      repeat (300) step(8'($urandom), ($urandom_range(0, 3) != 0));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
